// File: rtl/tick_event_display_pkg.sv
// Shared constants for the tick event display: channel/digit counts and the
// active-low seven-segment codes (bit order g,f,e,d,c,b,a).
package tick_event_display_pkg;

   localparam int NUM_CH     = 3;
   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   // Non-BCD codes cannot be produced by the counters; show them blank.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/tick_event_display_edge_sync.sv
// One-channel synchroniser followed by a rising-edge detector; emits a
// single-cycle pulse SYNC_STAGES edges after a rise is first sampled.
module edge_sync
   import tick_event_display_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_d,
   output logic o_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/tick_event_display.sv
// Counts rising edges on three slow channels in BCD and shows the counts on a
// 4-digit multiplexed active-low seven-segment display (digit 3 always blank).
module tick_event_display
   import tick_event_display_pkg::*;
#(
   parameter int SCAN_PERIOD = 100000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              sysclk,
   input  logic              rstn,
   input  logic [NUM_CH-1:0] q_in,
   input  logic              clr,
   input  logic              hold,
   output logic [3:0]        an,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [NUM_CH-1:0] ovf
);

   localparam int SCAN_W = $clog2(SCAN_PERIOD);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

   logic [NUM_CH-1:0] w_pulse;
   logic [3:0]        r_count [NUM_CH];
   logic [NUM_CH-1:0] r_ovf;
   logic [SCAN_W-1:0] r_scan_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [3:0]        r_an;
   logic [6:0]        r_seg;
   logic              r_dp;
   logic [3:0]        w_an_nxt;
   logic [6:0]        w_seg_nxt;
   logic              w_dp_nxt;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      edge_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_edge_sync (
         .i_clk   (sysclk),
         .i_rstn  (rstn),
         .i_d     (q_in[g]),
         .o_pulse (w_pulse[g])
      );
   end

   // Edge detectors run regardless of clr/hold, so a pulse seen here while
   // either is active is simply dropped rather than deferred.
   always_ff @(posedge sysclk) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_CH; i++) r_count[i] <= 4'd0;
         r_ovf <= '0;
      end else if (clr) begin
         for (int i = 0; i < NUM_CH; i++) r_count[i] <= 4'd0;
         r_ovf <= '0;
      end else if (!hold) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_pulse[i]) begin
               if (r_count[i] == 4'd9) begin
                  r_count[i] <= 4'd0;
                  r_ovf[i]   <= 1'b1;
               end else begin
                  r_count[i] <= r_count[i] + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (!rstn) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt <= '0;
         r_idx      <= r_idx + IDX_W'(1);
      end else begin
         r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
   end

   always_comb begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = SEG_BLANK;
      w_dp_nxt  = 1'b1;
      case (r_idx)
         2'd0: begin
            w_seg_nxt = bcd_to_seg(r_count[0]);
            w_dp_nxt  = ~r_ovf[0];
         end
         2'd1: begin
            w_seg_nxt = bcd_to_seg(r_count[1]);
            w_dp_nxt  = ~r_ovf[1];
         end
         2'd2: begin
            w_seg_nxt = bcd_to_seg(r_count[2]);
            w_dp_nxt  = ~r_ovf[2];
         end
         default: begin
            w_seg_nxt = SEG_BLANK;
            w_dp_nxt  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!rstn) begin
         r_an  <= 4'b1111;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;
   assign ovf = r_ovf;

endmodule

// File: doc/tick_event_display.md
Name: tick_event_display

Overview:
- Downstream consumer of the counter/divider stage's slow square-wave outputs (three channels), all in the sysclk domain.
- Synchronises each channel, detects rising edges and counts them per channel in BCD (0-9).
- Drives a 4-digit, active-low, multiplexed seven-segment display showing the three counts, with a per-channel overflow flag on the decimal points.

Parameters:
- SCAN_PERIOD, 100000: sysclk cycles each digit stays active; minimum 2; test benches use 4.
- SYNC_STAGES, 2: synchroniser depth per channel; minimum 2.

Ports:
- sysclk  in   1  system clock; all logic is on the rising edge.
- rstn    in   1  synchronous, active-low reset.
- q_in    in   3  slow counter outputs; bit0=Q1, bit1=Q2, bit2=Q3; asynchronous to sysclk phase.
- clr     in   1  synchronous clear of all counts and overflow flags.
- hold    in   1  1 = freeze counts; edges arriving during hold are dropped, not queued.
- an      out  4  digit anodes, active-low; an[i] selects digit i.
- seg     out  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a.
- dp      out  1  decimal point, active-low.
- ovf     out  3  sticky per-channel overflow flags.

Behaviour:
- Reset (rstn=0 at an edge):
  - sync flops, edge-detect flops, counts, ovf, scan counter and digit index all go to 0.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Synchroniser / edge detect:
  - Each q_in bit passes through SYNC_STAGES flops, then a "prev" flop.
  - pulse[i] = sync_out[i] & ~prev[i].
  - A q_in rise first sampled at edge k makes the count update at edge k+SYNC_STAGES (k+2 by default).
  - Exactly one increment per rising edge, regardless of how long q_in stays high.
- Count, per channel (4-bit BCD):
  - Increment on pulse while hold=0 and clr=0.
  - 9 -> 0 wraps and sets ovf[i]=1; ovf stays set until clr or reset.
- Priority: rstn > clr > hold > pulse.
  - clr=1: counts and ovf go to 0 at that edge; a coincident pulse is discarded.
  - hold=1: a coincident pulse is discarded.
  - Edge detection keeps running during hold and clr, so no spurious pulse appears when either deasserts.
- Scan:
  - scan counter runs 0..SCAN_PERIOD-1.
  - At terminal count the digit index advances 0->1->2->3->0 and the scan counter wraps to 0.
- Outputs (registered, one cycle behind the digit index and counts):
  - an = ~(1<<idx).
  - Digit 0/1/2: seg = bcd_to_seg(count[idx]), dp = ~ovf[idx].
  - Digit 3: always blank (seg=7'b1111111, dp=1), but its anode is still scanned.
  - The first edge after reset release gives an=1110 and seg=1000000 ("0").
- Reset mid-scan: at the next edge, outputs return to reset values and the scan restarts at digit 0.
- BCD encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10-15 never occur; they map to blank.

Decomposition:
- Shared package contains:
  - localparams NUM_CH=3 and NUM_DIGITS=4.
  - SEG_BLANK constant.
  - the ten segment-code constants and a bcd_to_seg function.
- One natural sub-module, edge_sync (synchroniser + rising-edge detect, parameter SYNC_STAGES), instantiated once per channel.
- Counting, scan and output registers stay in the top module.

Test Plan:
(all with SCAN_PERIOD=4, SYNC_STAGES=2)
1. Reset: hold rstn=0 for 2 edges -> an=1111, seg=1111111, dp=1, ovf=000. First edge after release -> an=1110, seg=1000000.
2. Single pulse: q_in[0] rises before edge k and stays high 6 cycles -> count0=1 from edge k+2 onward and never 2. During the next digit-0 window seg=1111001.
3. Overflow: 10 rising edges on q_in[1], each high and low for 3 cycles -> count1=0, ovf=010. While an=1101: seg=1000000, dp=0.
4. clr vs pulse: clr=1 on the same edge as a ch2 pulse, with count2=5 -> count2=0, ovf[2]=0. The next ch2 rise gives count2=1.
5. Hold: hold=1 across 3 rises on ch0 (count0=1) -> count0 stays 1. Release hold, then 1 rise -> count0=2; no spurious increment at release.
6. Scan and mid-scan reset:
   - Free run -> an = 1110 x4, 1101 x4, 1011 x4, 0111 x4, repeating; seg=1111111 while an=0111.
   - rstn=0 during the 1011 window -> an=1111 at the next edge.
   - After release, the sequence restarts at 1110.
